// File: rtl/stream_serializer.sv
// Parallel-to-serial converter with a valid/ready input handshake and back-to-back word streaming.
// Optional trailing XOR parity bit is enabled by defining STREAM_SERIALIZER_PARITY_EN.
module stream_serializer #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              stream_out,
    output logic              stream_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef STREAM_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              stream_out_n, stream_valid_n, out_last_n, busy_n;
    logic              last_data, handshake, load;
`ifdef STREAM_SERIALIZER_PARITY_EN
    logic              par, par_n;
`endif

    // The bit currently at the output end of the shift register, and the register after one shift.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    assign last_data = (state == SHIFT) && (cnt == LAST_CNT);
`ifdef STREAM_SERIALIZER_PARITY_EN
    assign in_ready  = (state == IDLE) || (state == PARITY);
`else
    assign in_ready  = (state == IDLE) || last_data;
`endif
    assign handshake = in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n        = state;
        shreg_n        = shreg;
        cnt_n          = cnt;
        stream_out_n   = 1'b0;
        stream_valid_n = 1'b0;
        out_last_n     = 1'b0;
        load           = 1'b0;
`ifdef STREAM_SERIALIZER_PARITY_EN
        par_n          = par;
`endif
        case (state)
            IDLE: load = handshake;
            SHIFT: begin
                if (!last_data) begin
                    cnt_n          = cnt + 1'b1;
                    shreg_n        = advance(shreg);
                    stream_valid_n = 1'b1;
                    stream_out_n   = head_bit(advance(shreg));
`ifndef STREAM_SERIALIZER_PARITY_EN
                    out_last_n     = ((cnt + 1'b1) == LAST_CNT);
`endif
                end else begin
`ifdef STREAM_SERIALIZER_PARITY_EN
                    state_n        = PARITY;
                    stream_valid_n = 1'b1;
                    stream_out_n   = par;
                    out_last_n     = 1'b1;
`else
                    load           = handshake;
                    state_n        = IDLE;
                    shreg_n        = '0;
                    cnt_n          = '0;
`endif
                end
            end
`ifdef STREAM_SERIALIZER_PARITY_EN
            PARITY: begin
                load    = handshake;
                state_n = IDLE;
                shreg_n = '0;
                cnt_n   = '0;
            end
`endif
            default: state_n = IDLE;
        endcase

        // A handshake overrides the return to IDLE, giving gapless word-to-word streaming.
        if (load) begin
            state_n        = SHIFT;
            shreg_n        = in_data;
            cnt_n          = '0;
            stream_valid_n = 1'b1;
            stream_out_n   = head_bit(in_data);
            out_last_n     = 1'b0;
`ifdef STREAM_SERIALIZER_PARITY_EN
            par_n          = ^in_data;
`endif
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            stream_out   <= 1'b0;
            stream_valid <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
`ifdef STREAM_SERIALIZER_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            cnt          <= cnt_n;
            stream_out   <= stream_out_n;
            stream_valid <= stream_valid_n;
            out_last     <= out_last_n;
            busy         <= busy_n;
`ifdef STREAM_SERIALIZER_PARITY_EN
            par          <= par_n;
`endif
        end
    end

endmodule
